// File: rtl/axil_reg_slave_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
// Holds response codes, the write/read FSM state encodings and index sizing.
// No logic of its own; imported by the top and the register bank.
package axil_reg_slave_pkg;

    // AXI response codes; the top casts these to its response field width.
    typedef enum logic [2:0] {
        RESP_OKAY   = 3'd0,
        RESP_EXOKAY = 3'd1,
        RESP_SLVERR = 3'd2,
        RESP_DECERR = 3'd3
    } axi_resp_e;

    // Write channel: address and data may arrive together or in either order.
    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } wr_state_e;

    // Read channel: accept an address, then hold the data beat until taken.
    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Bits needed to select one of num_regs registers (at least one bit).
    function automatic int reg_idx_width(input int num_regs);
        return (num_regs < 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Bank of 32-bit registers with one byte-strobed write port and one read port.
// Latency: write lands on the enable edge; read data registered one cycle after rd_en_i.
// Backpressure: none; the read result holds until the next rd_en_i.
module axil_reg_bank
    import axil_reg_slave_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = reg_idx_width(NUM_REGS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [31:0]      wr_data_i,
    input  logic [3:0]       wr_strb_i,
    input  logic             rd_en_i,
    input  logic             rd_clr_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rd_data_o
);

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] rd_data_q;

    // Byte-lane write: only lanes with their strobe set are updated.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb_i[b]) begin
                    regs_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    // Read samples the array before this edge's write lands, so a same-edge
    // collision returns the old contents. rd_clr_i forces a zero result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_clr_i ? 32'h0 : regs_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers in a window at BASE_ADDR.
// Latency: B valid one cycle after the last of AW/W; R valid one cycle after AR.
// Backpressure: B and R beats hold stable until taken; channel readies stay low meanwhile.
module axil_reg_slave
    import axil_reg_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int NUM_REGS   = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [DATA_WIDTH/8:0] s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [RESP_WIDTH-1:0] s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [RESP_WIDTH-1:0] s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int IDX_W = reg_idx_width(NUM_REGS);
    // Byte offset bits inside the window; the window is aligned to its size,
    // so an address is in range exactly when the bits above this match the base.
    localparam int OFS_W = IDX_W + 2;
    localparam logic [31:0] WIN_TAG = 32'(BASE_ADDR) >> OFS_W;
    localparam logic [RESP_WIDTH-1:0] RSP_OKAY   = RESP_WIDTH'(RESP_OKAY);
    localparam logic [RESP_WIDTH-1:0] RSP_SLVERR = RESP_WIDTH'(RESP_SLVERR);

    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        return (32'(addr) >> OFS_W) == WIN_TAG;
    endfunction

    // Write channel state
    wr_state_e             wstate_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [RESP_WIDTH-1:0] bresp_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wstrb_q;

    // Read channel state
    rd_state_e             rstate_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [RESP_WIDTH-1:0] rresp_q;

    // Handshakes and commit-side selections
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  wr_commit;
    logic                  wr_in_win;
    logic                  ar_in_win;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_d;
    logic [3:0]            wr_strb_d;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [31:0]           bank_rdata;

    // The strobe port carries one spare bit above the four byte lanes.
    logic unused_wstrb_msb;
    assign unused_wstrb_msb = s_axi_wstrb[DATA_WIDTH/8];

    assign aw_hs = s_axi_awvalid && awready_q;
    assign w_hs  = s_axi_wvalid  && wready_q;
    assign ar_hs = s_axi_arvalid && arready_q;

    // On the committing edge, whichever half arrives now comes straight from
    // the bus; the half that arrived earlier comes from its holding register.
    assign wr_addr_d = aw_hs ? s_axi_awaddr     : awaddr_q;
    assign wr_data_d = w_hs  ? s_axi_wdata      : wdata_q;
    assign wr_strb_d = w_hs  ? s_axi_wstrb[3:0] : wstrb_q;
    assign wr_in_win = in_window(wr_addr_d);
    assign wr_idx    = wr_addr_d[OFS_W-1:2];

    assign ar_in_win = in_window(s_axi_araddr);
    assign rd_idx    = s_axi_araddr[OFS_W-1:2];

    // Commit happens on the edge that completes the address/data pair.
    always_comb begin
        wr_commit = 1'b0;
        case (wstate_q)
            W_IDLE:      wr_commit = aw_hs && w_hs;
            W_HAVE_ADDR: wr_commit = w_hs;
            W_HAVE_DATA: wr_commit = aw_hs;
            default:     wr_commit = 1'b0;
        endcase
    end

    // Write FSM: collect AW and W in any order, commit, then hold B until taken.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    // Readies rise one cycle after arriving here (also after reset).
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    if (aw_hs) begin
                        awaddr_q <= s_axi_awaddr;
                    end
                    if (w_hs) begin
                        wdata_q <= s_axi_wdata;
                        wstrb_q <= s_axi_wstrb[3:0];
                    end
                    if (aw_hs && w_hs) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        wstate_q  <= W_RESP;
                    end else if (aw_hs) begin
                        awready_q <= 1'b0;
                        wstate_q  <= W_HAVE_ADDR;
                    end else if (w_hs) begin
                        wready_q <= 1'b0;
                        wstate_q <= W_HAVE_DATA;
                    end
                end
                W_HAVE_ADDR: begin
                    if (w_hs) begin
                        wready_q <= 1'b0;
                        wstate_q <= W_RESP;
                    end
                end
                W_HAVE_DATA: begin
                    if (aw_hs) begin
                        awready_q <= 1'b0;
                        wstate_q  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q <= 1'b0;
                        wstate_q <= W_IDLE;
                    end
                end
                default: begin
                    wstate_q <= W_IDLE;
                end
            endcase
            if (wr_commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_in_win ? RSP_OKAY : RSP_SLVERR;
            end
        end
    end

    // Read FSM: accept one address, present the beat, wait for it to be taken.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rresp_q   <= ar_in_win ? RSP_OKAY : RSP_SLVERR;
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        rvalid_q <= 1'b0;
                        rstate_q <= R_IDLE;
                    end
                end
                default: begin
                    rstate_q <= R_IDLE;
                end
            endcase
        end
    end

    axil_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk_i     (s_axi_aclk),
        .rst_ni    (s_axi_aresetn),
        .wr_en_i   (wr_commit && wr_in_win),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data_d),
        .wr_strb_i (wr_strb_d),
        .rd_en_i   (ar_hs),
        .rd_clr_i  (!ar_in_win),
        .rd_idx_i  (rd_idx),
        .rd_data_o (bank_rdata)
    );

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = bank_rdata;

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite responder: a bank of NUM_REGS 32-bit read/write registers behind one slave-side AXI-Lite port.
- Attaches to one master-side port (m1/m2) of the bus interconnect and completes the write and read transactions the interconnect forwards.
- Write channel and read channel are independent and may operate concurrently. Address decode is window-local; out-of-window accesses get an error response.

Parameters:
- DATA_WIDTH, 32, data bus width; fixed at 32 for this block.
- ADDR_WIDTH, 8, byte address width.
- RESP_WIDTH, 3, response field width: OKAY=0, SLVERR=2, DECERR=3.
- NUM_REGS, 4, number of 32-bit registers; power of two, 2..64.
- BASE_ADDR, 0, byte base of the register window; aligned to NUM_REGS*4.

Ports:
- s_axi_aclk  in  1  clock; all logic on rising edge.
- s_axi_aresetn  in  1  reset, synchronous, active-low.
- s_axi_awaddr  in  ADDR_WIDTH  write byte address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  DATA_WIDTH/8+1  byte enables; bits [3:0] used, top bit ignored.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  RESP_WIDTH  write response.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  ADDR_WIDTH  read byte address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  RESP_WIDTH  read response.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.

Behaviour:
- Reset (aresetn=0 at a rising edge):
  - All outputs 0: awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata.
  - All registers 0.
  - Any in-flight transaction is discarded; no bvalid or rvalid is produced for it.
- Address decode:
  - In window when BASE_ADDR <= addr < BASE_ADDR+NUM_REGS*4.
  - Index = addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored.
- Outputs: all registered; no combinational path from any input to any output.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: awready=1, wready=1.
    - Both handshakes on the same edge: latch both, go to W_RESP.
    - AW only: latch address, go to W_HAVE_ADDR, awready->0.
    - W only: latch data and strobe, go to W_HAVE_DATA, wready->0.
  - W_HAVE_ADDR: wready=1. On W handshake go to W_RESP.
  - W_HAVE_DATA: awready=1. On AW handshake go to W_RESP.
  - Entering W_RESP:
    - Register update on that same edge, byte lane i written only if wstrb[i]=1.
    - bvalid=1 on the following cycle; awready=wready=0.
    - bresp=OKAY if in window; SLVERR if out of window, with no register change.
  - W_RESP: hold bvalid and bresp stable until bready=1. On that edge go to W_IDLE; bvalid->0, awready/wready->1 next cycle.
- Write throughput: at most one write per 3 cycles when bready is held at 1.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake:
    - Capture rdata from the register array and set rvalid=1, both on the next cycle.
    - rresp=OKAY in window. Out of window: rresp=SLVERR, rdata=0.
    - Go to R_DATA.
  - R_DATA: arready=0; rdata, rresp and rvalid held stable until rready=1, then go to R_IDLE.
- Read latency: one cycle from AR handshake to rvalid.
- Simultaneous events:
  - A read captured on the same edge as a write commit to the same register returns the pre-write value.
  - Read and write FSMs never block each other.
- valid deasserted before its handshake: tolerated. Nothing is latched.
- Strobe 0000 in window: bresp=OKAY, register unchanged.

Decomposition:
- Shared package holds:
  - AXI response constants OKAY/EXOKAY/SLVERR/DECERR at RESP_WIDTH.
  - Write-FSM state enum and read-FSM state enum.
  - Function computing the register index width from NUM_REGS.
- One natural sub-module: axil_reg_bank.
  - Register array with byte-strobed write port and one synchronous read port.
  - Read-before-write on same-address collision.
- The top level holds both FSMs and the decode.

Test Plan:
- Reset: aresetn=0 for 2 cycles, then 1 -> all outputs 0 during reset; awready=wready=arready=1 on the cycle after release; read of addr 0 returns 0, OKAY.
- Write 0x38 to addr 0 with wstrb=0xF, AW and W on the same edge, bready=1 -> bvalid one cycle later with bresp=0; read addr 0 -> rdata=0x00000038, rresp=0, rvalid one cycle after the AR handshake.
- Split write with W arriving 3 cycles before AW: data 0xAABBCCDD, wstrb=0x5, addr 8, prior contents 0x11223344 -> wready=0 until AW arrives; then bresp=0, and a read of addr 8 returns 0x11BB33DD.
- Backpressure: bready=0 for 5 cycles after bvalid, and rready=0 for 4 cycles after rvalid -> bvalid/bresp and rvalid/rdata held stable; awready, wready and arready stay 0 until the respective handshake.
- Out of window (BASE_ADDR=16, NUM_REGS=4): write 0x31 to addr 0, then read addr 40 -> bresp=2 with registers unchanged; rresp=2, rdata=0.
- Collision: reg 1 holds 0x5; write 0x7 to addr 4 committing on the same edge as an AR for addr 4 -> rdata=0x5; the next read returns 0x7. Also assert reset while bvalid=1 -> bvalid=0 after that edge and no stale response after release.
